// File: rtl/button_event_gen.sv
// button_event_gen: turns one debounced button level into single-cycle
// press / release / short / long / auto-repeat event pulses, plus a held
// level and a per-hold repeat counter. All outputs are registered.
module button_event_gen #(
    parameter int unsigned CNT_W         = 24,
    parameter int unsigned LONG_CYCLES   = 10_000_000,
    parameter int unsigned REPEAT_CYCLES = 2_500_000,
    parameter bit          REPEAT_EN     = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       debounced,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       short_pulse,
    output logic       long_pulse,
    output logic       repeat_pulse,
    output logic       held,
    output logic [7:0] repeat_cnt
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESSED   = 2'd1,
        LONG_HELD = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    state_t           state, state_n;
    logic             prev;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             press_n, release_n, short_n, long_n, repeat_n, held_n;
    logic [7:0]       repeat_cnt_n;

    logic rise, fall;
    assign rise = debounced && !prev;
    assign fall = !debounced && (state != IDLE);

    // State, hold counter, input history and registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            prev          <= 1'b0;
            cnt           <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_pulse   <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
            held          <= 1'b0;
            repeat_cnt    <= '0;
        end else begin
            state         <= state_n;
            prev          <= debounced;
            cnt           <= cnt_n;
            press_pulse   <= press_n;
            release_pulse <= release_n;
            short_pulse   <= short_n;
            long_pulse    <= long_n;
            repeat_pulse  <= repeat_n;
            held          <= held_n;
            repeat_cnt    <= repeat_cnt_n;
        end
    end

    // Next-state and next-output logic; a fall always beats a threshold hit
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        press_n      = 1'b0;
        release_n    = 1'b0;
        short_n      = 1'b0;
        long_n       = 1'b0;
        repeat_n     = 1'b0;
        held_n       = held;
        repeat_cnt_n = repeat_cnt;

        unique case (state)
            IDLE: begin
                if (rise) begin
                    press_n      = 1'b1;
                    held_n       = 1'b1;
                    cnt_n        = '0;
                    repeat_cnt_n = '0;
                    state_n      = PRESSED;
                end
            end
            PRESSED: begin
                if (fall) begin
                    release_n = 1'b1;
                    short_n   = 1'b1;
                    held_n    = 1'b0;
                    cnt_n     = '0;
                    state_n   = IDLE;
                end else if (cnt == LONG_LAST) begin
                    long_n  = 1'b1;
                    cnt_n   = '0;
                    state_n = LONG_HELD;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            LONG_HELD: begin
                if (fall) begin
                    release_n = 1'b1;
                    held_n    = 1'b0;
                    cnt_n     = '0;
                    state_n   = IDLE;
                end else if (REPEAT_EN) begin
                    if (cnt == REPEAT_LAST) begin
                        repeat_n = 1'b1;
                        cnt_n    = '0;
                        if (repeat_cnt != 8'hFF) begin
                            repeat_cnt_n = repeat_cnt + 8'd1;
                        end
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end else begin
                    cnt_n = '0;
                end
            end
            default: begin
                held_n  = 1'b0;
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_button_event_gen.sv
// Testbench for button_event_gen (LONG_CYCLES=8, REPEAT_CYCLES=4): a
// vector table plus hand-written hold sequences, checked through a
// scoreboard queue; a second instance covers REPEAT_EN=0.
module tb_button_event_gen;

    typedef struct packed {
        logic       press;
        logic       rel;
        logic       shrt;
        logic       lng;
        logic       rep;
        logic       held;
        logic [7:0] rcnt;
    } exp_t;

    typedef struct packed {
        logic rst;
        logic deb;
        exp_t e;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset, debounced;
    logic       press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse, held;
    logic [7:0] repeat_cnt;

    logic       reset_b, deb_b;
    logic       press_b, release_b, short_b, long_b, repeat_b, held_b;
    logic [7:0] rcnt_b;

    int   checks = 0;
    int   errors = 0;
    exp_t sbq[$];
    vec_t tbl[12];

    always #5 clk = ~clk;

    button_event_gen #(.CNT_W(8), .LONG_CYCLES(8), .REPEAT_CYCLES(4), .REPEAT_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .debounced(debounced),
        .press_pulse(press_pulse), .release_pulse(release_pulse),
        .short_pulse(short_pulse), .long_pulse(long_pulse),
        .repeat_pulse(repeat_pulse), .held(held), .repeat_cnt(repeat_cnt)
    );

    button_event_gen #(.CNT_W(8), .LONG_CYCLES(8), .REPEAT_CYCLES(4), .REPEAT_EN(1'b0)) dut_norep (
        .clk(clk), .reset(reset_b), .debounced(deb_b),
        .press_pulse(press_b), .release_pulse(release_b),
        .short_pulse(short_b), .long_pulse(long_b),
        .repeat_pulse(repeat_b), .held(held_b), .repeat_cnt(rcnt_b)
    );

    function automatic exp_t mk(input logic p, input logic r, input logic s,
                                input logic l, input logic rp, input logic h,
                                input logic [7:0] rc);
        exp_t e;
        e.press = p; e.rel = r; e.shrt = s; e.lng = l; e.rep = rp; e.held = h; e.rcnt = rc;
        return e;
    endfunction

    task automatic check(input string tag);
        exp_t a, e;
        a = {press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse, held, repeat_cnt};
        checks++;
        if (sbq.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, got %b", tag, a);
        end else begin
            e = sbq.pop_front();
            if (a !== e) begin
                errors++;
                $display("FAIL %s: got p/r/s/l/rp/h=%b rcnt=%0d, expected p/r/s/l/rp/h=%b rcnt=%0d",
                         tag, a[13:8], a.rcnt, e[13:8], e.rcnt);
            end
        end
    endtask

    task automatic drive(input logic r, input logic d, input exp_t e, input string tag);
        @(negedge clk);
        reset     = r;
        debounced = d;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        check(tag);
    endtask

    task automatic cmp(input string tag, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    initial begin
        int longs, reps;
        reset = 1'b0; debounced = 1'b0; reset_b = 1'b0; deb_b = 1'b0;

        // reset, a 3-edge short press and a 1-edge blip
        tbl[0]  = '{1'b0, 1'b0, mk(0,0,0,0,0,0,0)};
        tbl[1]  = '{1'b0, 1'b0, mk(0,0,0,0,0,0,0)};
        tbl[2]  = '{1'b0, 1'b0, mk(0,0,0,0,0,0,0)};
        tbl[3]  = '{1'b1, 1'b0, mk(0,0,0,0,0,0,0)};
        tbl[4]  = '{1'b1, 1'b1, mk(1,0,0,0,0,1,0)};
        tbl[5]  = '{1'b1, 1'b1, mk(0,0,0,0,0,1,0)};
        tbl[6]  = '{1'b1, 1'b1, mk(0,0,0,0,0,1,0)};
        tbl[7]  = '{1'b1, 1'b0, mk(0,1,1,0,0,0,0)};
        tbl[8]  = '{1'b1, 1'b0, mk(0,0,0,0,0,0,0)};
        tbl[9]  = '{1'b1, 1'b1, mk(1,0,0,0,0,1,0)};
        tbl[10] = '{1'b1, 1'b0, mk(0,1,1,0,0,0,0)};
        tbl[11] = '{1'b1, 1'b0, mk(0,0,0,0,0,0,0)};
        for (int i = 0; i < 12; i++)
            drive(tbl[i].rst, tbl[i].deb, tbl[i].e, $sformatf("vec%0d", i));

        // high for exactly 8 edges: fall coincides with long threshold
        for (int i = 0; i < 8; i++)
            drive(1'b1, 1'b1, mk(i == 0, 0, 0, 0, 0, 1, 0), $sformatf("edge8_hold%0d", i));
        drive(1'b1, 1'b0, mk(0,1,1,0,0,0,0), "edge8_fall");

        // long hold: long at E0+8, repeats at E0+12/16/20
        for (int i = 0; i <= 20; i++) begin
            logic rp;
            rp = (i >= 12) && ((i - 8) % 4 == 0);
            drive(1'b1, 1'b1,
                  mk(i == 0, 0, 0, i == 8, rp, 1, (i < 12) ? 8'd0 : 8'((i - 8) / 4)),
                  $sformatf("long_hold%0d", i));
        end
        drive(1'b1, 1'b0, mk(0,1,0,0,0,0,3), "long_release");
        drive(1'b1, 1'b0, mk(0,0,0,0,0,0,3), "long_after");

        // reset mid-hold at E0+10, then re-press with input still high
        for (int i = 0; i < 10; i++)
            drive(1'b1, 1'b1, mk(i == 0, 0, 0, i == 8, 0, 1, 0), $sformatf("rst_hold%0d", i));
        drive(1'b0, 1'b1, mk(0,0,0,0,0,0,0), "rst_mid");
        drive(1'b1, 1'b1, mk(1,0,0,0,0,1,0), "rst_repress");
        drive(1'b1, 1'b1, mk(0,0,0,0,0,1,0), "rst_hold_again");
        drive(1'b1, 1'b0, mk(0,1,1,0,0,0,0), "rst_short_rel");

        // REPEAT_EN=0 instance: 30-edge hold
        longs = 0; reps = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            reset_b = 1'b1;
            deb_b   = 1'b1;
            @(posedge clk);
            #1;
            longs += int'(long_b);
            reps  += int'(repeat_b);
            cmp($sformatf("norep_edge%0d", i),
                {4'd0, press_b, long_b, repeat_b, held_b},
                {4'd0, i == 0, i == 8, 1'b0, 1'b1});
        end
        @(negedge clk);
        deb_b = 1'b0;
        @(posedge clk);
        #1;
        cmp("norep_release", {5'd0, release_b, short_b, held_b}, {5'd0, 1'b1, 1'b0, 1'b0});
        cmp("norep_rcnt", rcnt_b, 8'd0);
        cmp("norep_longs", 8'(longs), 8'd1);
        cmp("norep_repeats", 8'(reps), 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
